// File: rtl/dmem_arbiter.sv
// dmem_arbiter: two-requester round-robin arbiter that sequences one-cycle accesses
// to a shared single-port data memory and rejects misaligned or out-of-range addresses.
module dmem_arbiter #(
   parameter int MEM_BYTES = 101,
   parameter int ADDR_W = 64,
   parameter int DATA_W = 64
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              req0,
   input  logic              we0,
   input  logic [ADDR_W-1:0] addr0,
   input  logic [DATA_W-1:0] wdata0,
   output logic              done0,
   output logic              err0,
   input  logic              req1,
   input  logic              we1,
   input  logic [ADDR_W-1:0] addr1,
   input  logic [DATA_W-1:0] wdata1,
   output logic              done1,
   output logic              err1,
   output logic [DATA_W-1:0] rdata,
   output logic              busy,
   output logic [ADDR_W-1:0] Mem_Addr,
   output logic [DATA_W-1:0] WriteData,
   output logic              MemWrite,
   output logic              MemRead,
   input  logic [DATA_W-1:0] ReadData
);
   typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;
   state_t state, state_n;
   logic prio, owner, we_q, gnt, legal, g_we;
   logic [ADDR_W-1:0] g_addr;
   logic [DATA_W-1:0] g_wdata;
   always_comb begin
      gnt = req1 & (~req0 | prio);
      g_we = gnt ? we1 : we0;
      g_addr = gnt ? addr1 : addr0;
      g_wdata = gnt ? wdata1 : wdata0;
      // the extra top bit keeps addresses near the end of the space from wrapping into range
      legal = (g_addr[2:0] == 3'b000) &&
              ({1'b0, g_addr} + (ADDR_W+1)'(8) <= (ADDR_W+1)'(MEM_BYTES));
      state_n = state == ACCESS ? RESP :
                state == RESP ? IDLE :
                !(req0 | req1) ? IDLE :
                legal ? ACCESS : RESP;
   end
   always_ff @(posedge clk) state <= reset ? IDLE : state_n;
   assign busy = state != IDLE;
   assign MemWrite = state == ACCESS && we_q && !reset;
   assign MemRead = state == ACCESS && !we_q && !reset;
   always_ff @(posedge clk) begin
      if (reset) begin
         prio <= 1'b0;
         owner <= 1'b0;
         we_q <= 1'b0;
         done0 <= 1'b0;
         done1 <= 1'b0;
         err0 <= 1'b0;
         err1 <= 1'b0;
         rdata <= '0;
         Mem_Addr <= '0;
         WriteData <= '0;
      end else begin
         done0 <= 1'b0;
         done1 <= 1'b0;
         err0 <= 1'b0;
         err1 <= 1'b0;
         if (state == IDLE && (req0 | req1)) begin
            owner <= gnt;
            we_q <= g_we;
            prio <= ~gnt;
            if (legal) begin
               Mem_Addr <= g_addr;
               WriteData <= g_wdata;
            end else begin
               rdata <= '0;
               err0 <= ~gnt;
               err1 <= gnt;
            end
         end
         if (state == ACCESS) begin
            if (!we_q) rdata <= ReadData;
            done0 <= ~owner;
            done1 <= owner;
         end
      end
   end
endmodule

// File: tb/tb_dmem_arbiter.sv
// tb_dmem_arbiter: directed and randomized checks of dmem_arbiter against a
// transaction-level model of arbitration order, legality and memory contents.
module tb_dmem_arbiter;
   localparam int MB = 101;
   logic clk = 1'b0;
   logic reset = 1'b1;
   logic mem_init = 1'b1;
   logic req0 = 1'b0, we0 = 1'b0, req1 = 1'b0, we1 = 1'b0;
   logic [63:0] addr0 = '0, wdata0 = '0, addr1 = '0, wdata1 = '0;
   logic done0, err0, done1, err1, busy, MemWrite, MemRead;
   logic [63:0] rdata, Mem_Addr, WriteData, ReadData;
   logic [7:0] mem [0:MB-1];
   logic [63:0] ref_dw [0:11];
   int n_chk = 0;
   int n_fail = 0;
   bit prio_m;
   logic [63:0] rdata_m;

   always #5 clk = ~clk;

   dmem_arbiter dut (
      .clk(clk), .reset(reset),
      .req0(req0), .we0(we0), .addr0(addr0), .wdata0(wdata0), .done0(done0), .err0(err0),
      .req1(req1), .we1(we1), .addr1(addr1), .wdata1(wdata1), .done1(done1), .err1(err1),
      .rdata(rdata), .busy(busy), .Mem_Addr(Mem_Addr), .WriteData(WriteData),
      .MemWrite(MemWrite), .MemRead(MemRead), .ReadData(ReadData)
   );

   // memory: doubleword k initially holds 57+k
   always @(posedge clk) begin
      if (mem_init) begin
         for (int i = 0; i < MB; i++) mem[i] <= (i % 8 == 0) ? 8'(57 + i / 8) : 8'd0;
      end else if (MemWrite && Mem_Addr <= 64'(MB - 8)) begin
         for (int i = 0; i < 8; i++) mem[int'(Mem_Addr) + i] <= WriteData[8*i +: 8];
      end
   end

   always_comb begin
      ReadData = '0;
      if (Mem_Addr <= 64'(MB - 8))
         for (int i = 0; i < 8; i++) ReadData[8*i +: 8] = mem[int'(Mem_Addr) + i];
   end

   task automatic tick();
      @(negedge clk);
   endtask

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_chk++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic do_reset();
      reset = 1'b1;
      tick();
      tick();
      reset = 1'b0;
      prio_m = 1'b0;
      rdata_m = '0;
   endtask

   task automatic await_resp(input bit r, input bit w, input logic [63:0] a,
                             input logic [63:0] d, input int extra);
      bit legal, acc_w;
      int cyc, acc, bsy;
      logic [63:0] acc_a;
      legal = (a % 64'd8 == 64'd0) && (a <= 64'(MB - 8));
      cyc = 0;
      acc = 0;
      bsy = 0;
      acc_a = '0;
      acc_w = 1'b0;
      do begin
         tick();
         cyc++;
         if (busy) bsy++;
         if (MemRead || MemWrite) begin
            acc++;
            acc_a = Mem_Addr;
            acc_w = MemWrite;
         end
      end while (!(done0 || done1 || err0 || err1) && cyc < 10);
      chk("resp_kind", 64'({done0, done1, err0, err1}),
          legal ? (r ? 64'h4 : 64'h8) : (r ? 64'h1 : 64'h2));
      chk("latency", 64'(cyc), 64'((legal ? 2 : 1) + extra));
      chk("busy_cycles", 64'(bsy), legal ? 64'd2 : 64'd1);
      chk("access_count", 64'(acc), legal ? 64'd1 : 64'd0);
      if (legal) begin
         chk("access_addr", acc_a, a);
         chk("access_we", 64'(acc_w), 64'(w));
         if (w) ref_dw[int'(a / 64'd8)] = d;
         else rdata_m = ref_dw[int'(a / 64'd8)];
      end else rdata_m = '0;
      chk("rdata", rdata, rdata_m);
      prio_m = !r;
      if (r) req1 = 1'b0;
      else req0 = 1'b0;
   endtask

   task automatic txn(input bit r, input bit w, input logic [63:0] a, input logic [63:0] d);
      if (r) begin
         req1 = 1'b1; we1 = w; addr1 = a; wdata1 = d;
      end else begin
         req0 = 1'b1; we0 = w; addr0 = a; wdata0 = d;
      end
      await_resp(r, w, a, d, 0);
      tick();
   endtask

   task automatic pair(input bit wa, input logic [63:0] aa, input logic [63:0] da,
                       input bit wb, input logic [63:0] ab, input logic [63:0] db);
      bit first;
      req0 = 1'b1; we0 = wa; addr0 = aa; wdata0 = da;
      req1 = 1'b1; we1 = wb; addr1 = ab; wdata1 = db;
      first = prio_m;
      if (first) begin
         await_resp(1'b1, wb, ab, db, 0);
         await_resp(1'b0, wa, aa, da, 1);
      end else begin
         await_resp(1'b0, wa, aa, da, 0);
         await_resp(1'b1, wb, ab, db, 1);
      end
      tick();
   endtask

   function automatic logic [63:0] rnd_addr();
      int k = $urandom_range(0, 5);
      if (k <= 2) return 64'(8 * $urandom_range(0, 11));
      if (k == 3) return 64'(8 * $urandom_range(0, 11) + $urandom_range(1, 7));
      if (k == 4) return 64'(8 * $urandom_range(12, 30));
      return 64'hFFFF_FFFF_FFFF_FFF8 - 64'(8 * $urandom_range(0, 3));
   endfunction

   initial begin
      for (int k = 0; k < 12; k++) ref_dw[k] = 64'(57 + k);
      do_reset();
      mem_init = 1'b0;
      for (int i = 0; i < 5; i++) begin
         tick();
         chk("idle_ctrl", 64'({busy, done0, done1, err0, err1, MemWrite, MemRead}), 64'd0);
         chk("idle_rdata", rdata, 64'd0);
         chk("idle_addr", Mem_Addr, 64'd0);
         chk("idle_wdata", WriteData, 64'd0);
      end
      txn(1'b0, 1'b0, 64'd0, 64'd0);
      chk("fresh_read0", rdata, 64'd57);
      txn(1'b0, 1'b1, 64'd16, 64'hDEADBEEF00000001);
      txn(1'b0, 1'b0, 64'd16, 64'd0);
      chk("readback16", rdata, 64'hDEADBEEF00000001);
      txn(1'b0, 1'b0, 64'd8, 64'd0);
      chk("neighbour8", rdata, 64'd58);

      do_reset();
      req0 = 1'b1; we0 = 1'b0; addr0 = 64'd0;
      req1 = 1'b1; we1 = 1'b0; addr1 = 64'd8;
      for (int g = 0; g < 4; g++) begin
         int cyc;
         bit exp_o;
         exp_o = prio_m;
         cyc = 0;
         do begin
            tick();
            cyc++;
         end while (!(done0 || done1) && cyc < 10);
         chk("rr_owner", 64'({done0, done1}), exp_o ? 64'h1 : 64'h2);
         chk("rr_rdata", rdata, exp_o ? 64'd58 : 64'd57);
         prio_m = !exp_o;
      end
      req0 = 1'b0;
      req1 = 1'b0;
      rdata_m = 64'd58;
      tick();

      txn(1'b1, 1'b1, 64'd4, 64'h1234);
      txn(1'b1, 1'b1, 64'd96, 64'h5678);
      txn(1'b1, 1'b1, 64'hFFFF_FFFF_FFFF_FFF8, 64'h9ABC);
      txn(1'b0, 1'b0, 64'd0, 64'd0);
      chk("after_err0", rdata, 64'd57);
      txn(1'b0, 1'b0, 64'd88, 64'd0);
      chk("after_err88", rdata, 64'd68);

      req0 = 1'b1; we0 = 1'b1; addr0 = 64'd24; wdata0 = 64'hFF;
      tick();
      chk("rst_pre_we", 64'(MemWrite), 64'd1);
      reset = 1'b1;
      #1;
      chk("rst_we_gated", 64'({MemWrite, MemRead}), 64'd0);
      tick();
      chk("rst_state", 64'({busy, done0, done1, err0, err1}), 64'd0);
      req0 = 1'b0;
      reset = 1'b0;
      prio_m = 1'b0;
      rdata_m = '0;
      chk("rst_rdata", rdata, rdata_m);
      tick();
      txn(1'b0, 1'b0, 64'd24, 64'd0);
      chk("rst_mem24", rdata, 64'd60);

      for (int i = 0; i < 40; i++) begin
         if ($urandom_range(0, 2) == 2)
            pair($urandom_range(0, 1) == 1, rnd_addr(), {$urandom, $urandom},
                 $urandom_range(0, 1) == 1, rnd_addr(), {$urandom, $urandom});
         else
            txn($urandom_range(0, 1) == 1, $urandom_range(0, 1) == 1, rnd_addr(),
                {$urandom, $urandom});
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule

// File: doc/dmem_arbiter.md
Name: dmem_arbiter

Overview:
Two-requester round-robin arbiter and access sequencer for the single-port, byte-addressed, 64-bit little-endian data memory (Data_Memory: combinational read, posedge write). Requester 0 is the core load/store path; requester 1 is the loader/debug port. The block latches the winning request, drives the memory port for exactly one ACCESS cycle, and returns a one-cycle done or err pulse with registered read data. Misaligned and out-of-range accesses are rejected without touching memory.

Parameters:
MEM_BYTES, 101, number of byte locations in the attached memory. Legal doubleword address A satisfies A[2:0]==0 and A+8 <= MEM_BYTES. Largest legal A at the default is 88.
ADDR_W, 64, address width.
DATA_W, 64, data width. Fixed at 8 bytes.

Ports:
clk  in  1  system clock; all state updates on posedge.
reset  in  1  synchronous, active-high reset.
req0  in  1  requester 0 request; held until done0 or err0.
we0  in  1  requester 0 write (1) / read (0).
addr0  in  64  requester 0 byte address.
wdata0  in  64  requester 0 write data.
done0  out  1  one-cycle pulse: requester 0 access completed.
err0  out  1  one-cycle pulse: requester 0 access rejected.
req1, we1, addr1, wdata1, done1, err1: same as above, for requester 1.
rdata  out  64  registered read data for the completing read; shared by both requesters.
busy  out  1  high when the FSM is not in IDLE.
Mem_Addr  out  64  memory address.
WriteData  out  64  memory write data.
MemWrite  out  1  memory write enable.
MemRead  out  1  memory read enable.
ReadData  in  64  memory read data; combinational from Mem_Addr.

Behaviour:
- Reset values: state=IDLE, prio=0, done0/1=0, err0/1=0, rdata=0, busy=0, MemWrite=0, MemRead=0, Mem_Addr=0, WriteData=0. Latched addr/wdata/we/owner registers cleared to 0.
- FSM states: IDLE, ACCESS, RESP.
- IDLE, no req: stay in IDLE.
- IDLE, one req: that requester wins.
- IDLE, both req: the requester equal to prio wins.
- On a win, latch owner, addr, wdata and we. Then:
  - legal address -> go to ACCESS;
  - illegal address (misaligned or out of range) -> go to RESP with err_flag=1. No ACCESS cycle is issued.
- prio toggles to the other requester on every win, including rejected ones. A persistent requester therefore never waits more than one access.
- ACCESS (exactly one cycle):
  - Mem_Addr = latched addr; WriteData = latched wdata.
  - MemWrite = we_q & ~reset; MemRead = ~we_q & ~reset. Both are gated combinationally so a reset asserted in this cycle suppresses the write.
  - On the clock edge, rdata <= ReadData for reads; rdata is unchanged for writes. Go to RESP.
- Outside ACCESS: MemWrite=0, MemRead=0; Mem_Addr and WriteData hold their last values.
- RESP (one cycle): pulse done<owner>, or err<owner> if err_flag is set. On an error, rdata is set to 0. Go to IDLE.
- Latency: request sampled at edge N. ACCESS occupies cycle N+1; done is high in cycle N+2. The next grant edge is N+3.
- The requester must drop req in the cycle after its done/err pulse. A req still high in IDLE is treated as a new request.
- Requests arriving while busy are ignored until IDLE; there is no queueing beyond the req level.
- The loser of simultaneous requests keeps req high and is guaranteed the next grant.
- Address arithmetic: A+8 is computed in ADDR_W+1 bits, so addresses near 2^64 are rejected, not wrapped.
- Reset in any state returns to IDLE on that edge. Any in-flight done/err is dropped and prio returns to 0.

Test Plan:
- Reset, then idle 5 cycles -> all outputs 0, busy=0, MemWrite/MemRead never high.
- req0 read at addr0=0 on a fresh memory -> MemRead high for one cycle with Mem_Addr=0; done0 two cycles after the sampling edge; rdata=64'd57; busy=1 for 2 cycles.
- req0 write addr0=16, wdata0=64'hDEADBEEF00000001, then req0 read addr0=16 -> rdata=64'hDEADBEEF00000001. Neighbouring addr 8 still reads 58.
- req0 and req1 both held high (reads at 0 and 8) for 4 grants after reset -> grants in order 0,1,0,1; each done pulse pairs with the right rdata (57, 58).
- req1 write at addr1=4 (misaligned) and at addr1=96 (out of range) -> err1 pulse one cycle after grant; MemWrite stays 0; rdata=0; later reads of 0 and 88 are unchanged.
- reset asserted during the ACCESS cycle of a write of 64'hFF to addr 24 -> MemWrite=0 in that cycle; addr 24 still reads 60; no done0; state=IDLE the next cycle.
